// File: rtl/ondra_kbd_pkg.sv
// Shared definitions for the Ondra keyboard event scheduler:
// ps2_key field positions, auto-type entry layout and FSM states.
package ondra_kbd_pkg;

    // ps2_key event layout: [10] toggle strobe, [9] pressed, [8] extended, [7:0] code
    localparam int STB = 10;
    localparam int PRS = 9;
    localparam int EXT = 8;

    // Auto-type entry layout: {shift, extended, code[7:0]}
    localparam int AT_SHIFT = 9;
    localparam int AT_EXT   = 8;
    localparam int AT_W     = 10;

    // Left shift make/break code used for shifted auto-type characters
    localparam logic [7:0] SHIFT_CODE_DEF = 8'h12;

    typedef struct packed {
        logic       shift;
        logic       ext;
        logic [7:0] code;
    } at_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_DN,
        ST_PRESS,
        ST_HOLD,
        ST_RELEASE,
        ST_SHIFT_UP,
        ST_GAP
    } sched_state_e;

    // Build the 10-bit payload of a ps2_key event (strobe is added by the emitter)
    function automatic logic [9:0] mk_evt(input logic pressed, input logic ext, input logic [7:0] code);
        return {pressed, ext, code};
    endfunction

endpackage

// File: rtl/ondra_kbd_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and a flush input.
// A write and a pop in the same cycle are accepted even when full.
module ondra_kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    // Head is read combinationally so the scheduler can latch it the cycle it appears
    assign rd_data = mem[rd_ptr_q];

    // Pointer and occupancy update; flush discards everything including a same-cycle write
    always_comb begin
        do_wr    = wr_en & (~full | rd_en) & ~flush;
        do_rd    = rd_en & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ondra_kbd_sched.sv
// Merges live PS/2 events with queued auto-type keystrokes into one ps2_key
// stream. Live events win every cycle; auto-type expands each entry into
// shift-down / press / hold / release / shift-up / gap and can be aborted.
module ondra_kbd_sched
    import ondra_kbd_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [23:0] HOLD_CYCLES = 24'd400000,
    parameter logic [23:0] GAP_CYCLES  = 24'd400000,
    parameter logic [7:0]  SHIFT_CODE  = SHIFT_CODE_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key_in,
    input  logic        at_valid,
    input  logic [9:0]  at_data,
    output logic        at_ready,
    input  logic        at_abort,
    output logic [10:0] ps2_key_out,
    output logic        busy
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [23:0] HOLD_RELOAD = (HOLD_CYCLES == 24'd0) ? 24'd0 : HOLD_CYCLES - 24'd1;
    localparam logic [23:0] GAP_RELOAD  = (GAP_CYCLES == 24'd0) ? 24'd0 : GAP_CYCLES - 24'd1;

    sched_state_e state_q, state_d;
    logic [23:0]  timer_q, timer_d;
    at_entry_t    cur_q, cur_d;
    logic         aborting_q, aborting_d;
    logic         live_old_q, live_old_d;
    logic [10:0]  out_q, out_d;

    logic [9:0]   fifo_rd_data;
    logic         fifo_full;
    logic         fifo_empty;
    logic [AW:0]  fifo_count;
    logic         fifo_pop;
    at_entry_t    head;

    logic         live_evt;
    logic         busy_w;
    logic         abort;
    logic         auto_emit;
    logic [9:0]   auto_evt;
    logic [23:0]  timer_dec;
    logic         ab_any;

    assign head     = at_entry_t'(fifo_rd_data);
    assign busy_w   = (fifo_count != '0) | (state_q != ST_IDLE);
    assign live_evt = ps2_key_in[STB] ^ live_old_q;
    // A live key press while anything is queued or running cancels auto-type
    assign abort    = at_abort | (live_evt & ps2_key_in[PRS] & busy_w);
    assign at_ready = ~fifo_full;
    assign busy     = busy_w;
    assign ps2_key_out = out_q;

    ondra_kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (abort),
        .wr_en   (at_valid & ~fifo_full),
        .wr_data (at_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state, timer, emission and output merge for the keystroke sequencer
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cur_d      = cur_q;
        aborting_d = aborting_q;
        fifo_pop   = 1'b0;
        auto_emit  = 1'b0;
        auto_evt   = '0;
        ab_any     = aborting_q | abort;
        timer_dec  = (timer_q == '0) ? '0 : timer_q - 24'd1;

        case (state_q)
            ST_IDLE: begin
                aborting_d = 1'b0;
                if (!abort && !fifo_empty) begin
                    cur_d    = head;
                    fifo_pop = 1'b1;
                    state_d  = head.shift ? ST_SHIFT_DN : ST_PRESS;
                end
            end
            ST_SHIFT_DN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!live_evt) begin
                    auto_emit = 1'b1;
                    auto_evt  = mk_evt(1'b1, 1'b0, SHIFT_CODE);
                    state_d   = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (abort) begin
                    aborting_d = 1'b1;
                    state_d    = ST_RELEASE;
                end else if (!live_evt) begin
                    auto_emit = 1'b1;
                    auto_evt  = mk_evt(1'b1, cur_q.ext, cur_q.code);
                    timer_d   = HOLD_RELOAD;
                    // The release is emitted HOLD_CYCLES after the press
                    state_d   = (HOLD_CYCLES <= 24'd1) ? ST_RELEASE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    aborting_d = 1'b1;
                    state_d    = ST_RELEASE;
                end else begin
                    timer_d = timer_dec;
                    if (timer_q <= 24'd1) state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                aborting_d = ab_any;
                if (!live_evt) begin
                    auto_emit = 1'b1;
                    auto_evt  = mk_evt(1'b0, cur_q.ext, cur_q.code);
                    if (cur_q.shift) begin
                        state_d = ST_SHIFT_UP;
                    end else if (ab_any) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        timer_d = GAP_RELOAD;
                    end
                end
            end
            ST_SHIFT_UP: begin
                aborting_d = ab_any;
                if (!live_evt) begin
                    auto_emit = 1'b1;
                    auto_evt  = mk_evt(1'b0, 1'b0, SHIFT_CODE);
                    if (ab_any) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        timer_d = GAP_RELOAD;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_dec;
                    if (timer_q == '0) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        live_old_d = ps2_key_in[STB];
        out_d      = out_q;
        if (live_evt) begin
            out_d = {~out_q[STB], ps2_key_in[9:0]};
        end else if (auto_emit) begin
            out_d = {~out_q[STB], auto_evt};
        end
    end

    // Scheduler FSM and registered output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            cur_q      <= '0;
            aborting_q <= 1'b0;
            live_old_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cur_q      <= cur_d;
            aborting_q <= aborting_d;
            live_old_q <= live_old_d;
            out_q      <= out_d;
        end
    end

endmodule

// File: tb/tb_ondra_kbd_sched.sv
// Testbench for ondra_kbd_sched: per-cycle comparison against a script-based
// reference model, plus directed scenarios with hand-computed expectations.
module tb_ondra_kbd_sched;

    localparam int          DEPTH = 4;
    localparam logic [23:0] HOLD  = 24'd4;
    localparam logic [23:0] GAP   = 24'd3;
    localparam logic [7:0]  SHC   = 8'h12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] ps2_key_in = '0;
    logic        at_valid = 1'b0;
    logic [9:0]  at_data = '0;
    logic        at_abort = 1'b0;
    logic        at_ready;
    logic [10:0] ps2_key_out;
    logic        busy;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    ondra_kbd_sched #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .SHIFT_CODE  (SHC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ps2_key_in  (ps2_key_in),
        .at_valid    (at_valid),
        .at_data     (at_data),
        .at_ready    (at_ready),
        .at_abort    (at_abort),
        .ps2_key_out (ps2_key_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: each entry becomes a script of steps
    typedef enum {K_SDN, K_PRS, K_HOLD, K_REL, K_SUP, K_GAP} kind_e;
    typedef struct {
        kind_e      kind;
        logic [9:0] evt;
        int         n;
    } step_t;

    step_t       m_scr[$];
    logic [9:0]  m_q[$];
    logic [10:0] m_out = '0;
    logic        m_live_old = 1'b0;
    logic [9:0]  m_cur = '0;

    function automatic step_t mk(input kind_e k, input logic [9:0] e, input int n);
        step_t s;
        s.kind = k;
        s.evt  = e;
        s.n    = n;
        return s;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic  lv, ab, bz, wr, run;
        logic  [9:0] d;
        step_t s;
        if (!reset_n) begin
            m_q.delete();
            m_scr.delete();
            m_out      = '0;
            m_live_old = 1'b0;
        end else begin
            bz  = (m_q.size() != 0) || (m_scr.size() != 0);
            lv  = (ps2_key_in[10] != m_live_old);
            ab  = at_abort || (lv && ps2_key_in[9] && bz);
            wr  = at_valid && (m_q.size() < DEPTH) && !ab;
            run = (m_scr.size() != 0);
            if (ab) begin
                m_q.delete();
                if (m_scr.size() != 0) begin
                    case (m_scr[0].kind)
                        K_SDN, K_GAP: begin
                            m_scr.delete();
                            run = 1'b0;
                        end
                        K_PRS, K_HOLD: begin
                            m_scr.delete();
                            m_scr.push_back(mk(K_REL, {1'b0, m_cur[8:0]}, 0));
                            if (m_cur[9]) m_scr.push_back(mk(K_SUP, {2'b00, SHC}, 0));
                            run = 1'b0;
                        end
                        default: begin
                            if (m_scr[m_scr.size()-1].kind == K_GAP) void'(m_scr.pop_back());
                        end
                    endcase
                end
            end else if (m_scr.size() == 0 && m_q.size() != 0) begin
                d = m_q.pop_front();
                m_cur = d;
                if (d[9]) m_scr.push_back(mk(K_SDN, {2'b10, SHC}, 0));
                m_scr.push_back(mk(K_PRS, {1'b1, d[8:0]}, 0));
                if (HOLD > 1) m_scr.push_back(mk(K_HOLD, 10'h0, int'(HOLD) - 1));
                m_scr.push_back(mk(K_REL, {1'b0, d[8:0]}, 0));
                if (d[9]) m_scr.push_back(mk(K_SUP, {2'b00, SHC}, 0));
                if (GAP > 0) m_scr.push_back(mk(K_GAP, 10'h0, int'(GAP)));
                run = 1'b0;
            end
            if (run) begin
                s = m_scr[0];
                if (s.kind == K_HOLD || s.kind == K_GAP) begin
                    s.n = s.n - 1;
                    if (s.n == 0) void'(m_scr.pop_front());
                    else m_scr[0] = s;
                end else if (!lv) begin
                    m_out = {~m_out[10], s.evt};
                    void'(m_scr.pop_front());
                end
            end
            if (lv) m_out = {~m_out[10], ps2_key_in[9:0]};
            m_live_old = ps2_key_in[10];
            if (wr) m_q.push_back(at_data);
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        chk("out", 32'(ps2_key_out), 32'(m_out));
        chk("busy", 32'(busy), 32'((m_q.size() != 0) || (m_scr.size() != 0)));
        chk("ready", 32'(at_ready), 32'(m_q.size() < DEPTH));
    end

    // Log of DUT emissions and busy falling edges for the directed checks
    typedef struct {
        int         c;
        logic [9:0] evt;
    } ev_t;
    ev_t  dlog[$];
    logic prev_stb = 1'b0;
    logic prev_busy = 1'b0;
    int   busy_fall = -1;

    always @(negedge clk) begin
        ev_t e;
        if (reset_n && ps2_key_out[10] !== prev_stb) begin
            e.c   = cyc;
            e.evt = ps2_key_out[9:0];
            dlog.push_back(e);
        end
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
        prev_stb  = ps2_key_out[10];
        prev_busy = busy;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put(input logic [9:0] d);
        at_valid = 1'b1;
        at_data  = d;
        tick();
        at_valid = 1'b0;
    endtask

    function automatic logic [31:0] lev(input int i);
        if (i < dlog.size()) return 32'(dlog[i].evt);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int lcyc(input int i);
        if (i < dlog.size()) return dlog[i].c;
        return -1000;
    endfunction

    initial begin : stim
        int   k0;
        logic rdy3, rdy4;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_out", 32'(ps2_key_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(at_ready), 32'h1);
        #2 reset_n = 1'b1;
        repeat (3) tick();

        // Live-only event, one cycle latency
        dlog.delete();
        k0 = cyc;
        ps2_key_in = {~ps2_key_in[10], 1'b0, 1'b0, 8'h15};
        repeat (5) tick();
        chk("live_cnt", dlog.size(), 1);
        chk("live_evt", lev(0), 32'h015);
        chk("live_lat", lcyc(0) - k0, 1);
        chk("live_busy", 32'(busy), 32'h0);

        // Unshifted auto-type entry
        dlog.delete();
        k0 = cyc;
        put(10'h01C);
        repeat (20) tick();
        chk("a_cnt", dlog.size(), 2);
        chk("a_press", lev(0), 32'h21C);
        chk("a_press_t", lcyc(0) - k0, 3);
        chk("a_rel", lev(1), 32'h01C);
        chk("a_hold", lcyc(1) - lcyc(0), 4);
        chk("a_gap", busy_fall - lcyc(1), 3);

        // Shifted entry
        dlog.delete();
        k0 = cyc;
        put(10'h21C);
        repeat (25) tick();
        chk("s_cnt", dlog.size(), 4);
        chk("s_sdn", lev(0), 32'h212);
        chk("s_prs", lev(1), 32'h21C);
        chk("s_rel", lev(2), 32'h01C);
        chk("s_sup", lev(3), 32'h012);
        chk("s_t0", lcyc(0) - k0, 3);
        chk("s_t1", lcyc(1) - lcyc(0), 1);
        chk("s_t2", lcyc(2) - lcyc(1), 4);
        chk("s_t3", lcyc(3) - lcyc(2), 1);

        // Live release collides with auto press
        dlog.delete();
        k0 = cyc;
        put(10'h01C);
        tick();
        ps2_key_in = {~ps2_key_in[10], 1'b0, 1'b0, 8'h15};
        repeat (20) tick();
        chk("c_cnt", dlog.size(), 3);
        chk("c_live", lev(0), 32'h015);
        chk("c_live_t", lcyc(0) - k0, 3);
        chk("c_press", lev(1), 32'h21C);
        chk("c_press_t", lcyc(1) - k0, 4);
        chk("c_rel_t", lcyc(2) - k0, 8);

        // Abort during HOLD of a shifted key with more entries queued
        dlog.delete();
        k0 = cyc;
        put(10'h21C);
        for (int i = 0; i < 4; i++) put(10'h031 + 10'(i));
        at_abort = 1'b1;
        tick();
        at_abort = 1'b0;
        repeat (25) tick();
        chk("ab_cnt", dlog.size(), 4);
        chk("ab_rel", lev(2), 32'h01C);
        chk("ab_rel_t", lcyc(2) - k0, 7);
        chk("ab_sup", lev(3), 32'h012);
        chk("ab_sup_t", lcyc(3) - k0, 8);
        chk("ab_busy_t", busy_fall - k0, 8);

        // Fill past DEPTH while a blocker entry is holding
        dlog.delete();
        put(10'h040);
        tick();
        rdy3 = 1'b0;
        rdy4 = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            at_valid = 1'b1;
            at_data  = 10'h050 + 10'(i);
            if (i == 3) rdy3 = at_ready;
            if (i == 4) rdy4 = at_ready;
            tick();
        end
        at_valid = 1'b0;
        repeat (80) tick();
        chk("f_rdy3", 32'(rdy3), 32'h1);
        chk("f_rdy4", 32'(rdy4), 32'h0);
        chk("f_cnt", dlog.size(), 2 * (DEPTH + 1));
        chk("f_last", lev(2 * DEPTH + 1), 32'h053);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                tick();
                tick();
                #2 reset_n = 1'b1;
            end
            at_valid = ($urandom_range(0, 3) == 0);
            at_data  = 10'($urandom);
            at_abort = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0)
                ps2_key_in = {~ps2_key_in[10], ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom)};
            tick();
        end
        at_valid = 1'b0;
        at_abort = 1'b0;
        repeat (200) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
